// File: rtl/dino_pkg.sv
// Shared definitions for the dino-run pixel generator: colours, FSM encodings
// and the 16x16 dino bitmap.
package dino_pkg;

   localparam int SPRITE_W = 16;
   localparam int SPRITE_H = 16;
   localparam int CACTUS_H = 12;

   localparam logic [15:0] RGB_DINO   = 16'hFFFF;
   localparam logic [15:0] RGB_CACTUS = 16'h07E0;
   localparam logic [15:0] RGB_GROUND = 16'hA145;
   localparam logic [15:0] RGB_SKY    = 16'h001F;

   typedef enum logic [2:0] {
      PX_IDLE  = 3'd0,
      PX_FRAME = 3'd1,
      PX_FETCH = 3'd2,
      PX_SHADE = 3'd3,
      PX_DONE  = 3'd4
   } px_state_e;

   typedef enum logic [1:0] {
      JMP_GND  = 2'd0,
      JMP_RISE = 2'd1,
      JMP_FALL = 2'd2
   } jmp_state_e;

   // Sprite bitmap: bit {row[3:0], col[3:0]}; within each 16-bit row, bit c is
   // column c (LSB is the leftmost column). Row 0 is the top of the sprite.
   localparam logic [255:0] DINO_SPRITE = {
      16'h01B0,  // row 15
      16'h0090,  // row 14
      16'h00B0,  // row 13
      16'h01F8,  // row 12
      16'h03FC,  // row 11
      16'h07FE,  // row 10
      16'h07FF,  // row 9
      16'h07F3,  // row 8
      16'h1FE1,  // row 7
      16'h07C1,  // row 6
      16'h3F80,  // row 5
      16'h0F80,  // row 4
      16'hFF80,  // row 3
      16'hFF80,  // row 2
      16'hFD80,  // row 1
      16'h7F00   // row 0
   };

endpackage

// File: rtl/dino_sprite_rom.sv
// 256x1 dino sprite ROM with a registered read (one cycle of latency).
module dino_sprite_rom
   import dino_pkg::*;
(
   input  logic       clk_i,
   input  logic [7:0] addr_i,
   output logic       data_o
);

   logic data_q;

   // Registered lookup into the constant sprite bitmap
   always_ff @(posedge clk_i) begin
      data_q <= DINO_SPRITE[addr_i];
   end

   assign data_o = data_q;

endmodule

// File: rtl/dino_pixel_gen.sv
// Pixel source for the ST7735 driver: answers x/y requests with an RGB565
// colour and a one-cycle done pulse, and runs the dino-run game state
// (jump, scrolling cactus, sticky collision) once per frame at pixel (0,0).
module dino_pixel_gen
   import dino_pkg::*;
#(
   parameter int SCREEN_W = 161,
   parameter int SCREEN_H = 81,
   parameter int GROUND_Y = 64,
   parameter int DINO_X   = 16,
   parameter int JUMP_H   = 32,
   parameter int CACTUS_W = 6,
   parameter int SPEED    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  x,
   input  logic [6:0]  y,
   input  logic        next_pixel,
   input  logic        btn_jump,
   output logic [15:0] color,
   output logic        color_done,
   output logic        hit
);

   logic [1:0]  np_sync_q, btn_sync_q;
   logic        np_prev_q, btn_prev_q;
   logic        np_rise, btn_rise;

   px_state_e   state_q, state_d;
   jmp_state_e  jmp_q, jmp_d;
   logic [5:0]  jump_off_q, jump_off_d;
   logic [7:0]  cactus_x_q, cactus_x_d;
   logic        hit_q, hit_d;
   logic        pend_q, pend_d;
   logic        done_q, done_d;
   logic [15:0] color_q, color_d;

   logic [7:0]  x_q;
   logic [6:0]  y_q;
   logic        in_dino_q, in_cactus_q, ground_q, oob_q;
   logic [15:0] shade_q;

   logic [8:0]  x9, y9, dino_top, cact_l;
   logic        in_dino, in_cactus, on_ground, oob;
   logic [7:0]  rom_addr;
   logic        rom_bit;
   logic        dino_px;
   logic [15:0] shade;
   logic        is_origin;

   // Two-flop synchronisers with a trailing flop for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         np_sync_q  <= 2'b00;
         btn_sync_q <= 2'b00;
         np_prev_q  <= 1'b0;
         btn_prev_q <= 1'b0;
      end else begin
         np_sync_q  <= {np_sync_q[0], next_pixel};
         btn_sync_q <= {btn_sync_q[0], btn_jump};
         np_prev_q  <= np_sync_q[1];
         btn_prev_q <= btn_sync_q[1];
      end
   end

   assign np_rise   = np_sync_q[1] & ~np_prev_q;
   assign btn_rise  = btn_sync_q[1] & ~btn_prev_q;
   assign is_origin = (x == 8'd0) && (y == 7'd0);

   // Box and range tests on the latched pixel; 9-bit operands keep x+width from wrapping
   always_comb begin
      x9        = {1'b0, x_q};
      y9        = {2'b00, y_q};
      dino_top  = 9'(GROUND_Y - SPRITE_H) - {3'b000, jump_off_q};
      cact_l    = {1'b0, cactus_x_q};
      in_dino   = (x9 >= 9'(DINO_X)) && (x9 <= 9'(DINO_X + SPRITE_W - 1)) &&
                  (y9 >= dino_top) && (y9 <= dino_top + 9'(SPRITE_H - 1));
      in_cactus = (x9 >= cact_l) && (x9 <= cact_l + 9'(CACTUS_W - 1)) &&
                  (y9 >= 9'(GROUND_Y - CACTUS_H)) && (y9 <= 9'(GROUND_Y - 1));
      on_ground = (y9 >= 9'(GROUND_Y));
      oob       = (x9 >= 9'(SCREEN_W)) || (y9 >= 9'(SCREEN_H));
      rom_addr  = {y_q[3:0] - dino_top[3:0], x_q[3:0] - 4'(DINO_X)};
   end

   dino_sprite_rom u_rom (
      .clk_i  (clk),
      .addr_i (rom_addr),
      .data_o (rom_bit)
   );

   // Layer priority: off-screen sky, then dino, cactus, ground, sky
   always_comb begin
      dino_px = in_dino_q & rom_bit;
      shade   = RGB_SKY;
      if (oob_q)            shade = RGB_SKY;
      else if (dino_px)     shade = RGB_DINO;
      else if (in_cactus_q) shade = RGB_CACTUS;
      else if (ground_q)    shade = RGB_GROUND;
   end

   // Pixel datapath: request coordinates, registered box flags, shaded colour
   always_ff @(posedge clk) begin
      if (state_q == PX_IDLE && np_rise) begin
         x_q <= x;
         y_q <= y;
      end
      if (state_q == PX_FETCH) begin
         in_dino_q   <= in_dino;
         in_cactus_q <= in_cactus;
         ground_q    <= on_ground;
         oob_q       <= oob;
      end
      if (state_q == PX_SHADE) begin
         shade_q <= shade;
      end
   end

   // Pixel FSM next state plus the once-per-frame game update
   always_comb begin
      state_d    = state_q;
      jmp_d      = jmp_q;
      jump_off_d = jump_off_q;
      cactus_x_d = cactus_x_q;
      hit_d      = hit_q;
      pend_d     = pend_q | btn_rise;
      done_d     = 1'b0;
      color_d    = color_q;
      case (state_q)
         PX_IDLE: begin
            if (np_rise) state_d = is_origin ? PX_FRAME : PX_FETCH;
         end
         PX_FRAME: begin
            state_d = PX_FETCH;
            // A pending edge is consumed (or discarded) by every frame update
            pend_d  = btn_rise;
            if (hit_q) begin
               if (pend_q) begin
                  hit_d      = 1'b0;
                  jump_off_d = 6'd0;
                  cactus_x_d = 8'(SCREEN_W - 1);
                  jmp_d      = JMP_GND;
               end
            end else begin
               case (jmp_q)
                  JMP_GND: begin
                     if (pend_q) begin
                        jmp_d      = JMP_RISE;
                        jump_off_d = 6'd1;
                     end
                  end
                  JMP_RISE: begin
                     if (jump_off_q == 6'(JUMP_H)) begin
                        jmp_d      = JMP_FALL;
                        jump_off_d = jump_off_q - 6'd1;
                     end else begin
                        jump_off_d = jump_off_q + 6'd1;
                     end
                  end
                  JMP_FALL: begin
                     jump_off_d = jump_off_q - 6'd1;
                     if (jump_off_q == 6'd1) jmp_d = JMP_GND;
                  end
                  default: begin
                     jmp_d      = JMP_GND;
                     jump_off_d = 6'd0;
                  end
               endcase
               // Wrap when the post-move position would fall below SPEED
               if (cactus_x_q < 8'(2 * SPEED)) cactus_x_d = 8'(SCREEN_W - 1);
               else                            cactus_x_d = cactus_x_q - 8'(SPEED);
            end
         end
         PX_FETCH: begin
            state_d = PX_SHADE;
         end
         PX_SHADE: begin
            state_d = PX_DONE;
            if (dino_px && in_cactus_q) hit_d = 1'b1;
         end
         PX_DONE: begin
            state_d = PX_IDLE;
            done_d  = 1'b1;
            color_d = shade_q;
         end
         default: begin
            state_d = PX_IDLE;
         end
      endcase
   end

   // Control and game state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PX_IDLE;
         jmp_q      <= JMP_GND;
         jump_off_q <= 6'd0;
         cactus_x_q <= 8'(SCREEN_W - 1);
         hit_q      <= 1'b0;
         pend_q     <= 1'b0;
         done_q     <= 1'b0;
         color_q    <= 16'h0000;
      end else begin
         state_q    <= state_d;
         jmp_q      <= jmp_d;
         jump_off_q <= jump_off_d;
         cactus_x_q <= cactus_x_d;
         hit_q      <= hit_d;
         pend_q     <= pend_d;
         done_q     <= done_d;
         color_q    <= color_d;
      end
   end

   assign color      = color_q;
   assign color_done = done_q;
   assign hit        = hit_q;

endmodule

// File: tb/tb_dino_pixel_gen.sv
// Bench for dino_pixel_gen: directed scenarios plus random requests, checked
// against a frame-level game model written from the game rules.
module tb_dino_pixel_gen;

   localparam int W        = 161;
   localparam int H        = 81;
   localparam int GND_Y    = 64;
   localparam int DX       = 16;
   localparam int JH       = 32;
   localparam int CW       = 6;
   localparam int SPD      = 2;
   localparam int LAT_PIX  = 6;   // 2 sync flops + edge flop, then 4 clk to done
   localparam int LAT_FRM  = 7;

   logic        clk;
   logic        rst_n;
   logic [7:0]  x;
   logic [6:0]  y;
   logic        next_pixel;
   logic        btn_jump;
   logic [15:0] color;
   logic        color_done;
   logic        hit;

   int n_pass;
   int n_total;

   // Game model: m_k counts frames since a jump began (0 = on the ground)
   int   m_k;
   int   m_cx;
   logic m_hit;
   bit   m_pend;

   logic [15:0] m_rows [16] = '{
      16'h7F00, 16'hFD80, 16'hFF80, 16'hFF80, 16'h0F80, 16'h3F80, 16'h07C1, 16'h1FE1,
      16'h07F3, 16'h07FF, 16'h07FE, 16'h03FC, 16'h01F8, 16'h00B0, 16'h0090, 16'h01B0
   };

   dino_pixel_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .x          (x),
      .y          (y),
      .next_pixel (next_pixel),
      .btn_jump   (btn_jump),
      .color      (color),
      .color_done (color_done),
      .hit        (hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int m_off();
      return (m_k <= JH) ? m_k : 2 * JH - m_k;
   endfunction

   task automatic m_reset();
      m_k    = 0;
      m_cx   = W - 1;
      m_hit  = 1'b0;
      m_pend = 1'b0;
   endtask

   task automatic m_frame();
      int nx;
      if (m_hit) begin
         if (m_pend) begin
            m_hit = 1'b0;
            m_k   = 0;
            m_cx  = W - 1;
         end
      end else begin
         if (m_k == 0) begin
            if (m_pend) m_k = 1;
         end else begin
            m_k++;
            if (m_k == 2 * JH) m_k = 0;
         end
         nx = m_cx - SPD;
         if (nx < SPD) nx = W - 1;
         m_cx = nx;
      end
      m_pend = 1'b0;
   endtask

   task automatic m_pixel(input int px, input int py, output logic [15:0] c);
      int top;
      bit in_d, in_c, dbit;
      top  = GND_Y - 16 - m_off();
      in_d = (px >= DX) && (px < DX + 16) && (py >= top) && (py < top + 16);
      dbit = in_d ? m_rows[py - top][px - DX] : 1'b0;
      in_c = (px >= m_cx) && (px < m_cx + CW) && (py >= GND_Y - 12) && (py < GND_Y);
      if (px >= W || py >= H) c = 16'h001F;
      else if (dbit)          c = 16'hFFFF;
      else if (in_c)          c = 16'h07E0;
      else if (py >= GND_Y)   c = 16'hA145;
      else                    c = 16'h001F;
      if (dbit && in_c) m_hit = 1'b1;
   endtask

   task automatic request(input int rx, input int ry);
      int n;
      int exp_lat;
      logic [15:0] exp_c;
      @(negedge clk);
      x          = 8'(rx);
      y          = 7'(ry);
      next_pixel = 1'b1;
      if (rx == 0 && ry == 0) begin
         m_frame();
         exp_lat = LAT_FRM;
      end else begin
         exp_lat = LAT_PIX;
      end
      m_pixel(rx, ry, exp_c);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (color_done !== 1'b1 && n < 20);
      check("latency", 32'(n), 32'(exp_lat));
      check("color", {16'h0, color}, {16'h0, exp_c});
      check("hit", {31'h0, hit}, {31'h0, m_hit});
      @(posedge clk);
      #1;
      check("done_single", {31'h0, color_done}, 32'h0);
      check("color_held", {16'h0, color}, {16'h0, exp_c});
      @(negedge clk);
      next_pixel = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic press_button();
      @(negedge clk);
      btn_jump = 1'b1;
      repeat (4) @(negedge clk);
      btn_jump = 1'b0;
      repeat (4) @(negedge clk);
      m_pend = 1'b1;
   endtask

   initial begin
      int r;
      n_pass     = 0;
      n_total    = 0;
      x          = 8'd0;
      y          = 7'd0;
      next_pixel = 1'b0;
      btn_jump   = 1'b0;
      rst_n      = 1'b0;
      m_reset();

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_color", {16'h0, color}, 32'h0);
      check("rst_done", {31'h0, color_done}, 32'h0);
      check("rst_hit", {31'h0, hit}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Sky, ground, two frames moving the cactus, then the cactus itself
      request(5, 5);
      request(20, 70);
      request(0, 0);
      request(0, 0);
      request(157, 60);

      // Off-screen and edge coordinates
      request(161, 70);
      request(20, 81);
      request(160, 70);
      request(255, 127);

      // Full jump: dino top row tracked every frame
      press_button();
      for (int i = 0; i < 2 * JH; i++) begin
         request(0, 0);
         request(DX + 8, GND_Y - 16 - m_off());
      end

      // Move cactus onto the grounded dino, collide, freeze, restart
      for (int i = 0; i < 200 && !(m_cx == DX && m_k == 0); i++) request(0, 0);
      request(DX, GND_Y - 10);
      check("collide", {31'h0, hit}, 32'h1);
      repeat (3) request(0, 0);
      request(DX + 5, GND_Y - 12);
      check("frozen_cactus", {16'h0, color}, 32'h07E0);
      press_button();
      request(0, 0);
      check("restart_hit", {31'h0, hit}, 32'h0);
      request(W - 1, 60);
      check("restart_cactus", {16'h0, color}, 32'h07E0);

      // Random mix of frames, button presses and pixel requests
      for (int i = 0; i < 150; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2)       request(0, 0);
         else if (r == 2) press_button();
         else if (r < 6)  request(int'($urandom_range(10, 40)), int'($urandom_range(30, 70)));
         else             request(int'($urandom_range(0, 175)), int'($urandom_range(0, 95)));
      end

      // Reset while the FSM is in SHADE
      @(negedge clk);
      x          = 8'd40;
      y          = 7'd10;
      next_pixel = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst_n      = 1'b0;
      next_pixel = 1'b0;
      #1;
      check("midrst_color", {16'h0, color}, 32'h0);
      check("midrst_done", {31'h0, color_done}, 32'h0);
      check("midrst_hit", {31'h0, hit}, 32'h0);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("midrst_nodone", {31'h0, color_done}, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
      repeat (3) begin
         @(posedge clk);
         #1;
         check("post_rst_nodone", {31'h0, color_done}, 32'h0);
      end
      request(30, 20);
      request(157, 60);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
